// File: rtl/ram_rr_scheduler.sv
// Round-robin arbiter sharing one 8-bit RAM between NREQ bus masters.
// Grants are registered, bursts are bounded, and read data is routed back by a tag that follows the RAM pipeline.
module ram_rr_scheduler #(
  parameter int NREQ      = 3,
  parameter int MAX_BURST = 8
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [NREQ-1:0]      Req,
  input  logic [NREQ-1:0]      Lock,
  input  logic [NREQ-1:0]      Req_Wr,
  input  logic [NREQ-1:0][7:0] Req_Addr,
  input  logic [NREQ-1:0][7:0] Req_Data,
  output logic [NREQ-1:0]      Gnt,
  output logic [NREQ-1:0]      Rd_Valid,
  output logic [7:0]           Rd_Data,
  output logic                 Busy,
  output logic                 RAM_Cs,
  output logic                 RAM_Wen,
  output logic                 RAM_Oen,
  output logic [7:0]           RAM_Address,
  output logic [7:0]           RAM_DataIn,
  input  logic [7:0]           RAM_DataOut,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Handshake: a requester holds Req (level) until it sees Gnt; every cycle
  // where Gnt[i] and Req[i] are both high at a clock edge is one RAM access,
  // with Req_Wr/Req_Addr/Req_Data sampled on that same edge.

  logic [1:0]      state;
  logic [1:0]      owner;
  logic [1:0]      ptr;
  logic [7:0]      burst_cnt;

  logic            s1_v;
  logic [1:0]      s1_tag;
  logic            s2_v;
  logic [1:0]      s2_tag;

  logic            pick_found;
  logic [1:0]      pick_idx;
  logic [1:0]      cand;
  logic [NREQ-1:0] pick_oh;
  logic [NREQ-1:0] owner_oh;
  logic [NREQ-1:0] s2_oh;
  logic            others;
  logic            req_own;
  logic            lock_own;
  logic            issue;
  logic [8:0]      cnt_next;
  logic            at_max;
  logic [1:0]      ptr_adv;

  // Search starts at the rotating pointer and wraps, so the last owner goes to the back.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr;
    cand       = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      cand = 2'((int'(ptr) + i) % NREQ);
      if (!pick_found && Req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign pick_oh  = NREQ'(1) << pick_idx;
  assign owner_oh = NREQ'(1) << owner;
  assign s2_oh    = NREQ'(1) << s2_tag;
  assign others   = |(Req & ~owner_oh);
  assign req_own  = Req[owner];
  assign lock_own = Lock[owner];
  assign issue    = (state == ST_GRANT) && req_own;
  assign cnt_next = {1'b0, burst_cnt} + 9'd1;
  assign at_max   = (cnt_next == 9'(MAX_BURST));
  assign ptr_adv  = (owner == 2'(NREQ - 1)) ? 2'd0 : owner + 2'd1;

  assign Busy      = (state != ST_IDLE) | s1_v | s2_v;
  assign dbg_state = state;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= ST_IDLE;
      owner     <= 2'd0;
      ptr       <= 2'd0;
      burst_cnt <= 8'd0;
      Gnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          burst_cnt <= 8'd0;
          if (pick_found) begin
            state <= ST_GRANT;
            owner <= pick_idx;
            Gnt   <= pick_oh;
          end
        end
        ST_GRANT: begin
          // The access on the final granted edge still completes; Gnt drops on that same edge.
          if (!req_own || (others && (!lock_own || at_max))) begin
            state     <= ST_GAP;
            Gnt       <= '0;
            ptr       <= ptr_adv;
            burst_cnt <= 8'd0;
          end else if (at_max) begin
            burst_cnt <= 8'd0;
          end else begin
            burst_cnt <= cnt_next[7:0];
          end
        end
        ST_GAP: begin
          burst_cnt <= 8'd0;
          if (pick_found) begin
            state <= ST_GRANT;
            owner <= pick_idx;
            Gnt   <= pick_oh;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          Gnt       <= '0;
          burst_cnt <= 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      RAM_Cs      <= 1'b0;
      RAM_Wen     <= 1'b1;
      RAM_Oen     <= 1'b1;
      RAM_Address <= 8'd0;
      RAM_DataIn  <= 8'd0;
    end else if (issue) begin
      RAM_Cs      <= 1'b1;
      RAM_Wen     <= ~Req_Wr[owner];
      RAM_Oen     <= Req_Wr[owner];
      RAM_Address <= Req_Addr[owner];
      RAM_DataIn  <= Req_Data[owner];
    end else begin
      RAM_Cs  <= 1'b0;
      RAM_Wen <= 1'b1;
      RAM_Oen <= 1'b1;
    end
  end

  // Stage 1 aligns with the RAM strobes, stage 2 with RAM_DataOut; the tag rides along.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1_v     <= 1'b0;
      s1_tag   <= 2'd0;
      s2_v     <= 1'b0;
      s2_tag   <= 2'd0;
      Rd_Valid <= '0;
      Rd_Data  <= 8'd0;
    end else begin
      s1_v     <= issue & ~Req_Wr[owner];
      s1_tag   <= owner;
      s2_v     <= s1_v;
      s2_tag   <= s1_tag;
      Rd_Valid <= s2_v ? s2_oh : '0;
      if (s2_v) begin
        Rd_Data <= RAM_DataOut;
      end
    end
  end

endmodule

// File: tb/tb_ram_rr_scheduler.sv
// Directed bench for ram_rr_scheduler with a synchronous 256x8 RAM model.
module tb_ram_rr_scheduler;

  logic            Clk;
  logic            Rst_n;
  logic [2:0]      Req;
  logic [2:0]      Lock;
  logic [2:0]      Req_Wr;
  logic [2:0][7:0] Req_Addr;
  logic [2:0][7:0] Req_Data;
  logic [2:0]      Gnt;
  logic [2:0]      Rd_Valid;
  logic [7:0]      Rd_Data;
  logic            Busy;
  logic            RAM_Cs;
  logic            RAM_Wen;
  logic            RAM_Oen;
  logic [7:0]      RAM_Address;
  logic [7:0]      RAM_DataIn;
  logic [7:0]      RAM_DataOut;
  logic [1:0]      dbg_state;

  logic [7:0]      mem [256];
  int              checks;
  int              errors;

  ram_rr_scheduler #(.NREQ(3), .MAX_BURST(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Lock(Lock), .Req_Wr(Req_Wr),
    .Req_Addr(Req_Addr), .Req_Data(Req_Data), .Gnt(Gnt), .Rd_Valid(Rd_Valid),
    .Rd_Data(Rd_Data), .Busy(Busy), .RAM_Cs(RAM_Cs), .RAM_Wen(RAM_Wen),
    .RAM_Oen(RAM_Oen), .RAM_Address(RAM_Address), .RAM_DataIn(RAM_DataIn),
    .RAM_DataOut(RAM_DataOut), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // RAM model: write on Cs&!Wen, read data appears one cycle after Cs&!Oen.
  initial RAM_DataOut = 8'd0;
  always @(posedge Clk) begin
    if (RAM_Cs && !RAM_Wen) mem[RAM_Address] = RAM_DataIn;
    else if (RAM_Cs && !RAM_Oen) RAM_DataOut <= mem[RAM_Address];
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"}, 32'(Gnt), 32'h0);
    chk({tag, "_rdv"}, 32'(Rd_Valid), 32'h0);
    chk({tag, "_rdd"}, 32'(Rd_Data), 32'h0);
    chk({tag, "_busy"}, 32'(Busy), 32'h0);
    chk({tag, "_cs"}, 32'(RAM_Cs), 32'h0);
    chk({tag, "_wen"}, 32'(RAM_Wen), 32'h1);
    chk({tag, "_oen"}, 32'(RAM_Oen), 32'h1);
    chk({tag, "_addr"}, 32'(RAM_Address), 32'h0);
    chk({tag, "_din"}, 32'(RAM_DataIn), 32'h0);
    chk({tag, "_state"}, 32'(dbg_state), 32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h3C] = 8'hA5;
    mem[8'h55] = 8'h5A;

    // 1: reset with all requests held, then single-access rotation
    Rst_n = 1'b0;
    Req = 3'b111; Lock = 3'b000; Req_Wr = 3'b111;
    Req_Addr = {8'h30, 8'h20, 8'h10};
    Req_Data = {8'hC3, 8'hB2, 8'hA1};
    step(); step();
    chk_reset_vals("t1_rst");
    Rst_n = 1'b1;
    step(); chk("t1_gnt0", 32'(Gnt), 32'h1);
    step(); chk("t1_gap0", 32'(Gnt), 32'h0);
    chk("t1_cs0", 32'(RAM_Cs), 32'h1);
    chk("t1_wen0", 32'(RAM_Wen), 32'h0);
    chk("t1_addr0", 32'(RAM_Address), 32'h10);
    chk("t1_din0", 32'(RAM_DataIn), 32'hA1);
    step(); chk("t1_gnt1", 32'(Gnt), 32'h2);
    step(); chk("t1_gap1", 32'(Gnt), 32'h0);
    chk("t1_addr1", 32'(RAM_Address), 32'h20);
    step(); chk("t1_gnt2", 32'(Gnt), 32'h4);
    step(); chk("t1_gap2", 32'(Gnt), 32'h0);
    chk("t1_addr2", 32'(RAM_Address), 32'h30);
    Req = 3'b000;
    step(); chk("t1_idle_busy", 32'(Busy), 32'h0);
    chk("t1_idle_cs", 32'(RAM_Cs), 32'h0);

    // 2: single read by requester 1
    Req = 3'b010; Req_Wr = 3'b000; Req_Addr[1] = 8'h3C;
    step(); chk("t2_gnt", 32'(Gnt), 32'h2);
    step(); chk("t2_cs", 32'(RAM_Cs), 32'h1);
    chk("t2_oen", 32'(RAM_Oen), 32'h0);
    chk("t2_wen", 32'(RAM_Wen), 32'h1);
    chk("t2_addr", 32'(RAM_Address), 32'h3C);
    chk("t2_rdv_early", 32'(Rd_Valid), 32'h0);
    Req = 3'b000;
    step(); chk("t2_rdv_mid", 32'(Rd_Valid), 32'h0);
    chk("t2_busy_mid", 32'(Busy), 32'h1);
    chk("t2_cs_off", 32'(RAM_Cs), 32'h0);
    step(); chk("t2_rdv", 32'(Rd_Valid), 32'h2);
    chk("t2_rdd", 32'(Rd_Data), 32'hA5);
    step(); chk("t2_rdv_pulse", 32'(Rd_Valid), 32'h0);
    chk("t2_busy_end", 32'(Busy), 32'h0);

    // 3: locked burst by requester 0 cut at 8 accesses while requester 2 waits
    Req = 3'b001; Lock = 3'b001; Req_Wr = 3'b111;
    Req_Addr[0] = 8'h40; Req_Data[0] = 8'h00;
    step(); chk("t3_gnt", 32'(Gnt), 32'h1);
    Req = 3'b101;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("t3_cs_%0d", k), 32'(RAM_Cs), 32'h1);
      chk($sformatf("t3_addr_%0d", k), 32'(RAM_Address), 32'h40 + 32'(k - 1));
      chk($sformatf("t3_gnt_%0d", k), 32'(Gnt), (k < 8) ? 32'h1 : 32'h0);
      Req_Addr[0] = 8'(8'h40 + k);
      Req_Data[0] = 8'(k);
    end
    chk("t3_gap_state", 32'(dbg_state), 32'h2);
    step(); chk("t3_gnt2", 32'(Gnt), 32'h4);
    chk("t3_gap_cs", 32'(RAM_Cs), 32'h0);
    Req = 3'b000; Lock = 3'b000;
    step(); step();
    chk("t3_idle", 32'(dbg_state), 32'h0);

    // 4: locked burst of 12 with no competition keeps the grant
    Req = 3'b001; Lock = 3'b001; Req_Wr = 3'b001;
    Req_Addr[0] = 8'h80; Req_Data[0] = 8'h90;
    step(); chk("t4_gnt", 32'(Gnt), 32'h1);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("t4_gnt_%0d", k), 32'(Gnt), 32'h1);
      chk($sformatf("t4_addr_%0d", k), 32'(RAM_Address), 32'h80 + 32'(k - 1));
      Req_Addr[0] = 8'(8'h80 + k);
      Req_Data[0] = 8'(8'h90 + k);
    end
    Req = 3'b000; Lock = 3'b000;
    step(); step();
    for (int k = 0; k < 12; k++)
      chk($sformatf("t4_mem_%0d", k), 32'(mem[8'h80 + k]), 32'h90 + 32'(k));

    // 5: read from requester 0 returns to it after the grant has moved to 1
    Req = 3'b001; Req_Wr = 3'b010; Req_Addr[0] = 8'h55;
    Req_Addr[1] = 8'h66; Req_Data[1] = 8'h77;
    step(); chk("t5_gnt0", 32'(Gnt), 32'h1);
    Req = 3'b011;
    step(); chk("t5_gap", 32'(Gnt), 32'h0);
    chk("t5_oen", 32'(RAM_Oen), 32'h0);
    chk("t5_addr", 32'(RAM_Address), 32'h55);
    Req = 3'b010;
    step(); chk("t5_gnt1", 32'(Gnt), 32'h2);
    chk("t5_rdv_mid", 32'(Rd_Valid), 32'h0);
    step(); chk("t5_rdv", 32'(Rd_Valid), 32'h1);
    chk("t5_rdd", 32'(Rd_Data), 32'h5A);
    chk("t5_gnt1_hold", 32'(Gnt), 32'h2);
    chk("t5_wr_addr", 32'(RAM_Address), 32'h66);
    Req = 3'b000;
    step(); chk("t5_rdv_pulse", 32'(Rd_Valid), 32'h0);
    step();

    // 6: asynchronous reset during a locked read burst
    Req = 3'b001; Lock = 3'b001; Req_Wr = 3'b000; Req_Addr[0] = 8'h3C;
    step(); chk("t6_gnt", 32'(Gnt), 32'h1);
    step(); step();
    chk("t6_busy", 32'(Busy), 32'h1);
    Req = 3'b000; Lock = 3'b000;
    #2 Rst_n = 1'b0;
    #1 chk_reset_vals("t6_async");
    step();
    Rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t6_rdv_%0d", k), 32'(Rd_Valid), 32'h0);
      chk($sformatf("t6_rdd_%0d", k), 32'(Rd_Data), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
